// File: rtl/sub_unsigned64_pipe.sv
// rtl/sub_unsigned64_pipe.sv - pipelined unsigned subtractor with segmented carry chain
//
// Computes D = (A - B) mod 2^WIDTH and borrow = (A < B) as A + ~B + 1.
// The carry chain is cut into N = WIDTH/SEG segments with one segment per stage.
// Latency is N+2 ce-enabled edges. Throughput is one result per ce cycle.
//
// Ports:
//   clk       rising-edge clock
//   resetn    asynchronous active-low reset; clears valid bits, D and borrow
//   ce        clock enable; 0 freezes every register in the pipe
//   in_valid  A/B carry an operation (sampled when ce=1)
//   A, B      unsigned minuend / subtrahend
//   valid     D/borrow carry a result this cycle
//   D         difference A-B mod 2^WIDTH
//   borrow    1 when A < B
module sub_unsigned64_pipe #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             valid,
  output logic [WIDTH-1:0] D,
  output logic             borrow
);

  localparam int N = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_width_check
    $error("WIDTH must be an integer multiple of SEG");
  end

  // x_r[k]: segments below k hold finished difference bits, segments at or
  // above k still hold the raw minuend. nb_r carries ~B alongside.
  // nb_r stops at N-1 because the last stage consumes the top segment.
  logic [WIDTH-1:0] x_r   [0:N];
  logic [WIDTH-1:0] nb_r  [0:N-1];
  logic             c_r   [1:N];
  logic             v_r   [0:N];

  logic [SEG:0]     sum   [1:N];
  logic             cin   [1:N];
  logic [WIDTH-1:0] x_nxt [1:N];

  always_comb begin
    // The +1 of the two's-complement negation enters as carry-in of segment 0.
    cin[1] = 1'b1;
    for (int k = 2; k <= N; k++) begin
      cin[k] = c_r[k-1];
    end
    for (int k = 1; k <= N; k++) begin
      sum[k]   = {1'b0, x_r[k-1][(k-1)*SEG +: SEG]}
               + {1'b0, nb_r[k-1][(k-1)*SEG +: SEG]}
               + (SEG+1)'(cin[k]);
      x_nxt[k] = x_r[k-1];
      x_nxt[k][(k-1)*SEG +: SEG] = sum[k][SEG-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k <= N; k++) begin
        x_r[k] <= '0;
        v_r[k] <= 1'b0;
      end
      for (int k = 0; k < N; k++) begin
        nb_r[k] <= '0;
      end
      for (int k = 1; k <= N; k++) begin
        c_r[k] <= 1'b0;
      end
      valid  <= 1'b0;
      D      <= '0;
      borrow <= 1'b0;
    end else if (ce) begin
      // Data moves on every enabled edge; only the valid bits mark real work.
      x_r[0]  <= A;
      nb_r[0] <= ~B;
      v_r[0]  <= in_valid;
      for (int k = 1; k <= N; k++) begin
        x_r[k] <= x_nxt[k];
        c_r[k] <= sum[k][SEG];
        v_r[k] <= v_r[k-1];
      end
      for (int k = 1; k < N; k++) begin
        nb_r[k] <= nb_r[k-1];
      end
      D      <= x_r[N];
      // No carry out of A + ~B + 1 means B > A.
      borrow <= ~c_r[N];
      valid  <= v_r[N];
    end
  end

endmodule

// File: tb/tb_sub_unsigned64_pipe.sv
// tb/tb_sub_unsigned64_pipe.sv - self-checking bench for sub_unsigned64_pipe
module tb_sub_unsigned64_pipe;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ce;
  logic        in_valid;
  logic [63:0] A;
  logic [63:0] B;
  logic        valid;
  logic [63:0] D;
  logic        borrow;

  sub_unsigned64_pipe #(.WIDTH(64), .SEG(16)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .ce       (ce),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .valid    (valid),
    .D        (D),
    .borrow   (borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic        b;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ce_cnt = 0;
  logic edge_ce = 1'b0;
  logic        mv = 1'b0;
  logic [63:0] md = '0;
  logic        mb = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic v, input logic [63:0] a, input logic [63:0] b);
    @(posedge clk);
    #1;
    ce = c;
    in_valid = v;
    A = a;
    B = b;
  endtask

  // Scoreboard push at the sampling edge; due is the ce-count at which the
  // result register loads (sampling edge counts as the first of LAT).
  always @(posedge clk) begin
    edge_ce = ce && resetn;
    if (edge_ce) begin
      ce_cnt++;
      if (in_valid) q.push_back('{A - B, (A < B), ce_cnt + LAT - 1});
    end
  end

  always @(negedge resetn) begin
    q.delete();
    mv = 1'b0;
  end

  // Output model: advances only on ce edges, holds otherwise.
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_valid", 64'(valid), 64'(1'b0));
      chk("rst_D", D, 64'd0);
      chk("rst_borrow", 64'(borrow), 64'(1'b0));
    end else begin
      if (edge_ce) begin
        if (q.size() > 0 && q[0].due == ce_cnt) begin
          exp_t e;
          e  = q.pop_front();
          mv = 1'b1;
          md = e.d;
          mb = e.b;
        end else begin
          mv = 1'b0;
        end
      end
      chk("valid", 64'(valid), 64'(mv));
      if (mv) begin
        chk("D", D, md);
        chk("borrow", 64'(borrow), 64'(mb));
      end
    end
  end

  initial begin
    int pat [5];
    pat = '{1, 0, 1, 1, 0};
    resetn = 1'b0;
    ce = 1'b0;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", 64'(valid), 64'(1'b0));
    chk("init_D", D, 64'd0);
    chk("init_borrow", 64'(borrow), 64'(1'b0));
    resetn = 1'b1;

    // Single op 10-3
    drive(1, 1, 64'd10, 64'd3);
    repeat (8) drive(1, 0, 64'd0, 64'd0);

    // Borrow and full carry-chain span, then equal operands
    drive(1, 1, 64'd0, 64'd1);
    drive(1, 1, 64'h0001_0000_0000_0000, 64'd1);
    drive(1, 1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    drive(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    repeat (8) drive(1, 0, 64'hDEAD_BEEF_0000_0001, 64'd7);

    // Streaming 100 random pairs
    for (int i = 0; i < 100; i++) begin
      drive(1, 1, {$urandom, $urandom}, {$urandom, $urandom});
    end
    repeat (8) drive(1, 0, 64'd0, 64'd0);

    // Bubbles 1,0,1,1,0 with garbage data on the bubbles
    for (int i = 0; i < 5; i++) begin
      drive(1, pat[i][0], {$urandom, $urandom}, {$urandom, $urandom});
    end
    repeat (8) drive(1, 0, 64'd0, 64'd0);

    // Stall in flight, then hold a valid output for 4 stalled cycles
    drive(1, 1, 64'd100, 64'd250);
    drive(1, 0, 64'd0, 64'd0);
    repeat (3) drive(0, 0, 64'd0, 64'd0);
    drive(1, 0, 64'd0, 64'd0);
    @(negedge clk);
    for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
    chk("stall_arrive", 64'(valid), 64'(1'b1));
    ce = 1'b0;
    repeat (4) @(negedge clk);
    chk("stall_hold_D", D, 64'd100 - 64'd250);
    ce = 1'b1;
    repeat (8) drive(1, 0, 64'd0, 64'd0);

    // Reset mid-flight with 3 ops in the pipe; new op presented at release
    drive(1, 1, 64'd5, 64'd9);
    drive(1, 1, 64'd50, 64'd9);
    drive(1, 1, 64'd500, 64'd9);
    drive(1, 0, 64'd0, 64'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(valid), 64'(1'b0));
    chk("mid_rst_D", D, 64'd0);
    chk("mid_rst_borrow", 64'(borrow), 64'(1'b0));
    #3;
    in_valid = 1'b1;
    A = 64'd77;
    B = 64'd78;
    resetn = 1'b1;
    drive(1, 0, 64'd0, 64'd0);
    repeat (10) drive(1, 0, 64'd0, 64'd0);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
